// File: rtl/lfsr_candidate_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lfsr_candidate_gen : two XORed Galois LFSRs -> odd full-width candidates    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module lfsr_candidate_gen #(
   parameter int          NUM_BITS = 128,
   parameter logic [31:0] SEED_A   = 32'hACE1_2468,
   parameter logic [31:0] SEED_B   = 32'h1357_BDF9
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                i_start,
   input  logic [15:0]         i_num_candidates,
   input  logic                i_fifo_full,
   output logic                o_fifo_wr_en,
   output logic [NUM_BITS-1:0] o_fifo_din,
   output logic                o_busy,
   output logic                o_LFSR_Done
);

   localparam int                 WORDS      = NUM_BITS / 32;
   localparam int                 WCW        = $clog2(WORDS);
   localparam logic [WCW-1:0]     C_WLAST    = WCW'(WORDS - 1);
   localparam logic [31:0]        C_MASK_A   = 32'h8020_0003;
   localparam logic [31:0]        C_MASK_B   = 32'hA300_0000;
   localparam logic [31:0]        C_SEED_A   = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
   localparam logic [31:0]        C_SEED_B   = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
   localparam logic [NUM_BITS-1:0] C_FORCE   = {1'b1, {(NUM_BITS-2){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_GEN, S_WRITE, S_DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic [31:0]           r_a, r_b;
   logic [31:0]           w_a_nxt, w_b_nxt;
   logic [NUM_BITS-1:0]   r_cand, w_cand_nxt;
   logic [NUM_BITS-1:0]   r_din;
   logic [15:0]           r_remaining;
   logic [WCW-1:0]        r_wcnt;
   logic                  r_done;
   logic                  w_accept;
   logic                  w_wr;

   function automatic logic [31:0] f_step(input logic [31:0] s, input logic [31:0] m);
      f_step = s[0] ? ((s >> 1) ^ m) : (s >> 1);
   endfunction

   assign w_a_nxt    = f_step(r_a, C_MASK_A);
   assign w_b_nxt    = f_step(r_b, C_MASK_B);
   assign w_cand_nxt = {r_cand[NUM_BITS-33:0], w_a_nxt ^ w_b_nxt};
   assign w_accept   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   // Write strobe is combinational so a full FIFO blocks it in the same cycle.
   assign w_wr       = (r_state == S_WRITE) && !i_fifo_full;

   always_ff @(posedge aclk) begin
      if (!aresetn) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept)
               w_state_nxt = (i_num_candidates == 16'd0) ? S_DONE : S_GEN;
         end
         S_GEN: begin
            if (r_wcnt == C_WLAST) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            if (w_wr) w_state_nxt = (r_remaining == 16'd1) ? S_DONE : S_GEN;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_a         <= C_SEED_A;
         r_b         <= C_SEED_B;
         r_cand      <= '0;
         r_din       <= '0;
         r_remaining <= 16'd0;
         r_wcnt      <= '0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_remaining <= i_num_candidates;
                  r_wcnt      <= '0;
                  r_done      <= (i_num_candidates == 16'd0);
               end
            end
            S_GEN: begin
               r_a    <= w_a_nxt;
               r_b    <= w_b_nxt;
               r_cand <= w_cand_nxt;
               r_wcnt <= r_wcnt + 1'b1;
               // Output word is latched once so it stays stable across any stall.
               if (r_wcnt == C_WLAST) r_din <= w_cand_nxt | C_FORCE;
            end
            S_WRITE: begin
               if (w_wr) begin
                  r_remaining <= r_remaining - 16'd1;
                  r_wcnt      <= '0;
                  if (r_remaining == 16'd1) r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_fifo_wr_en = w_wr;
   assign o_fifo_din   = r_din;
   assign o_busy       = (r_state == S_GEN) || (r_state == S_WRITE);
   assign o_LFSR_Done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_candidate_gen.sv
`default_nettype none
// Bench for lfsr_candidate_gen: table of runs plus hand sequences, checked
// against a word-by-word candidate model of the two LFSRs.
module tb_lfsr_candidate_gen;
   localparam int NB    = 128;
   localparam int WORDS = NB / 32;

   logic          clk = 1'b0;
   logic          rstn, start, full, sel;
   logic [15:0]   num;
   logic          wr0, busy0, done0, wr1, busy1, done1;
   logic [NB-1:0] din0, din1;
   logic          w_wr, w_busy, w_done;
   logic [NB-1:0] w_din;

   always #5 clk = ~clk;

   lfsr_candidate_gen #(.NUM_BITS(NB)) u_dut (
      .aclk(clk), .aresetn(rstn), .i_start(start & ~sel), .i_num_candidates(num),
      .i_fifo_full(full), .o_fifo_wr_en(wr0), .o_fifo_din(din0), .o_busy(busy0),
      .o_LFSR_Done(done0));

   lfsr_candidate_gen #(.NUM_BITS(NB), .SEED_A(32'h0), .SEED_B(32'h0)) u_dut_z (
      .aclk(clk), .aresetn(rstn), .i_start(start & sel), .i_num_candidates(num),
      .i_fifo_full(full), .o_fifo_wr_en(wr1), .o_fifo_din(din1), .o_busy(busy1),
      .o_LFSR_Done(done1));

   assign w_wr   = sel ? wr1   : wr0;
   assign w_din  = sel ? din1  : din0;
   assign w_busy = sel ? busy1 : busy0;
   assign w_done = sel ? done1 : done0;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0]   mA [2];
   logic [31:0]   mB [2];
   logic [NB-1:0] seen_q [$];

   typedef struct {
      int n; int fs; int fl; bit stable; bit midst; int exp_done; int exp_first; int exp_last;
   } run_t;
   run_t tbl [5];

   task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] step(input logic [31:0] s, input logic [31:0] m);
      return s[0] ? ((s >> 1) ^ m) : (s >> 1);
   endfunction

   task automatic model_reset();
      mA[0] = 32'hACE1_2468; mB[0] = 32'h1357_BDF9;
      mA[1] = 32'h1;         mB[1] = 32'h1;
   endtask

   // Candidate = WORDS successive (A^B) words, first word most significant, ends forced to 1.
   task automatic model_cand(input int k, output logic [NB-1:0] c);
      c = '0;
      for (int w = 0; w < WORDS; w++) begin
         mA[k] = step(mA[k], 32'h8020_0003);
         mB[k] = step(mB[k], 32'hA300_0000);
         c = (c << 32) | NB'(mA[k] ^ mB[k]);
      end
      c[NB-1] = 1'b1;
      c[0]    = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rstn = 1'b0; start = 1'b0; full = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      model_reset();
   endtask

   task automatic run(input string nm, input int n, input int fs, input int fl, input bit stable,
                      input bit midst, input bit rnd, input int exp_done, input int exp_first,
                      input int exp_last);
      int writes = 0, first = -1, last = -1, done_c = -1;
      logic [NB-1:0] exp_c, held;
      held = '0;
      @(posedge clk); #1 start = 1'b1; num = 16'(n); full = 1'b0;
      for (int c = 1; c < 400 && done_c < 0; c++) begin
         @(posedge clk); #1;
         start = midst && (c == 2);
         num   = (midst && c == 2) ? 16'd7 : 16'(n);
         full  = rnd ? 1'($urandom_range(0, 1)) : (c >= fs && c < fs + fl);
         #1;
         if (w_wr) begin
            chk($sformatf("%s wr_while_full", nm), NB'(full), '0);
            model_cand(sel ? 1 : 0, exp_c);
            chk($sformatf("%s din", nm), w_din, exp_c);
            writes++;
            if (first < 0) first = c;
            last = c;
            seen_q.push_back(w_din);
         end
         if (stable && c == fs) held = w_din;
         if (stable && c > fs && c < fs + fl) chk($sformatf("%s din_held", nm), w_din, held);
         if (w_done) begin
            done_c = c;
            chk($sformatf("%s busy_at_done", nm), NB'(w_busy), '0);
         end
      end
      full = 1'b0; start = 1'b0;
      chk_i($sformatf("%s done_reached", nm), int'(done_c >= 0), 1);
      chk_i($sformatf("%s writes", nm), writes, n);
      if (exp_done >= 0)  chk_i($sformatf("%s done_cycle", nm), done_c, exp_done);
      if (exp_first >= 0) chk_i($sformatf("%s first_wr", nm), first, exp_first);
      if (exp_last >= 0)  chk_i($sformatf("%s last_wr", nm), last, exp_last);
   endtask

   logic [NB-1:0] t1_first;

   initial begin
      rstn = 1'b0; start = 1'b0; full = 1'b0; sel = 1'b0; num = 16'd0;
      // n, fs, fl, stable, midst, exp_done, exp_first, exp_last
      tbl[0] = '{3, 0, 0, 1'b0, 1'b0, 16, 5, 15};    // plain run
      tbl[1] = '{2, 5, 7, 1'b1, 1'b0, 18, 12, 17};   // stall at first write
      tbl[2] = '{0, 0, 0, 1'b0, 1'b0, 1, -1, -1};    // empty run
      tbl[3] = '{1, 1, 3, 1'b0, 1'b0, 6, 5, 5};      // full during GEN has no effect
      tbl[4] = '{2, 0, 0, 1'b0, 1'b1, 11, 5, 10};    // mid-run start ignored

      do_reset();
      chk("reset wr_en", NB'(w_wr), '0);
      chk("reset din",   w_din, '0);
      chk("reset busy",  NB'(w_busy), '0);
      chk("reset done",  NB'(w_done), '0);

      seen_q.delete();
      for (int i = 0; i < 5; i++) begin
         run($sformatf("tbl%0d", i), tbl[i].n, tbl[i].fs, tbl[i].fl, tbl[i].stable,
             tbl[i].midst, 1'b0, tbl[i].exp_done, tbl[i].exp_first, tbl[i].exp_last);
         if (i == 0 && seen_q.size() > 0) begin
            t1_first = seen_q[0];
            chk("t1 msb_lsb", NB'({seen_q[0][NB-1], seen_q[0][0]}), NB'(2'b11));
         end
      end

      // Reset in the middle of a run, then restart from the seeds.
      @(posedge clk); #1 start = 1'b1; num = 16'd5;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      chk("midreset wr_en", NB'(w_wr), '0);
      chk("midreset din",   w_din, '0);
      chk("midreset busy",  NB'(w_busy), '0);
      chk("midreset done",  NB'(w_done), '0);
      model_reset();
      seen_q.delete();
      run("restart", 1, 0, 0, 1'b0, 1'b0, 1'b0, 6, 5, 5);
      if (seen_q.size() > 0) chk("restart equals first", seen_q[0], t1_first);

      // Two back-to-back N=2 runs continue the same sequence as one N=4 run.
      run("chainA", 2, 0, 0, 1'b0, 1'b1, 1'b0, 11, 5, 10);
      run("chainB", 2, 0, 0, 1'b0, 1'b0, 1'b0, 11, 5, 10);

      for (int r = 0; r < 6; r++)
         run($sformatf("rnd%0d", r), int'($urandom_range(1, 4)), 0, 0, 1'b0, 1'b0, 1'b1, -1, -1, -1);

      // Zero seeds behave as seed 1; candidates must all differ.
      sel = 1'b1;
      seen_q.delete();
      run("zseed", 8, 0, 0, 1'b0, 1'b0, 1'b0, 8 * (WORDS + 1) + 1, 5, 8 * (WORDS + 1));
      for (int i = 0; i < seen_q.size(); i++)
         for (int j = i + 1; j < seen_q.size(); j++)
            chk_i($sformatf("zseed distinct %0d/%0d", i, j), int'(seen_q[i] != seen_q[j]), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
